game_sprite_spawn_ctrl: RTL and testbench

Sequencer for one sprite instance (control + display pair). On launch, or automatically after respawn, it loads a start position and velocity into the sprite and enables motion. It then tracks entry and exit of the visible screen and handles collisions with a freeze period. It sits between game-level logic and one sprite's write/enable ports.

---
 rtl/game_sprite_spawn_ctrl.sv | 169 ++++++++++++++++
 tb/tb_game_sprite_spawn_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sprite_spawn_ctrl.sv
// game_sprite_spawn_ctrl
// Launch/respawn sequencer for one sprite. It loads a start position and
// velocity, enables motion, watches screen entry/exit and freezes the sprite
// for a hold period after a collision. Every output is a registered decode of
// the next state, so each strobe lines up with the state it belongs to.
module game_sprite_spawn_ctrl #(
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int w_x           = $clog2(screen_width),
    parameter int w_y           = $clog2(screen_height),
    parameter int SPRITE_WIDTH  = 8,
    parameter int DX_WIDTH      = 2,
    parameter int DY_WIDTH      = 2,
    parameter int START_Y       = 0,
    parameter int RESPAWN_DELAY = 1000000,
    parameter int HIT_HOLD      = 500000,
    parameter int ENTER_TIMEOUT = 2000000,
    parameter int CNT_W         = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                launch,
    input  logic                abort,
    input  logic                auto_respawn,
    input  logic [DX_WIDTH-1:0] cfg_dx,
    input  logic [DY_WIDTH-1:0] cfg_dy,
    input  logic                collision,
    input  logic                sprite_within_screen,
    output logic                sprite_write_xy,
    output logic                sprite_write_dxy,
    output logic [w_x-1:0]      sprite_write_x,
    output logic [w_y-1:0]      sprite_write_y,
    output logic [DX_WIDTH-1:0] sprite_write_dx,
    output logic [DY_WIDTH-1:0] sprite_write_dy,
    output logic                sprite_enable_update,
    output logic                busy,
    output logic                hit,
    output logic                escaped,
    output logic [7:0]          spawn_count
);

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_LOAD_XY      = 3'd1,
        ST_LOAD_DXY     = 3'd2,
        ST_ENTER        = 3'd3,
        ST_RUN          = 3'd4,
        ST_HIT          = 3'd5,
        ST_RESPAWN_WAIT = 3'd6
    } state_t;

    // Last counter value of each timed state (counter starts at 0 on entry).
    localparam logic [CNT_W-1:0] ENTER_LAST   = CNT_W'(ENTER_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HIT_LAST     = CNT_W'(HIT_HOLD - 1);
    localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_DELAY - 1);
    // Largest legal X is X_LIMIT-1 so the whole sprite stays on screen.
    localparam logic [w_x-1:0]   X_LIMIT      = w_x'(screen_width - SPRITE_WIDTH);
    localparam logic [15:0]      LFSR_SEED    = 16'hACE1;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [15:0]      lfsr_r;

    // Fibonacci LFSR, taps 16,14,13,11; a nonzero seed never reaches zero.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    // Fold the raw LFSR bits into [0, X_LIMIT) with a single subtraction.
    function automatic logic [w_x-1:0] spawn_x(input logic [15:0] cur);
        logic [w_x-1:0] raw;
        raw = cur[w_x-1:0];
        if (raw >= X_LIMIT) begin
            return raw - X_LIMIT;
        end else begin
            return raw;
        end
    endfunction

    // Next-state decode; abort outranks collision, which outranks exit/timeout.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch) state_s = ST_LOAD_XY;
                    else        state_s = ST_IDLE;
                end
                ST_LOAD_XY:  state_s = ST_LOAD_DXY;
                ST_LOAD_DXY: state_s = ST_ENTER;
                ST_ENTER: begin
                    if (collision)                 state_s = ST_HIT;
                    else if (sprite_within_screen) state_s = ST_RUN;
                    else if (cnt_r == ENTER_LAST)  state_s = ST_RESPAWN_WAIT;
                    else                           state_s = ST_ENTER;
                end
                ST_RUN: begin
                    if (collision)                  state_s = ST_HIT;
                    else if (!sprite_within_screen) state_s = ST_RESPAWN_WAIT;
                    else                            state_s = ST_RUN;
                end
                ST_HIT: begin
                    if (cnt_r == HIT_LAST) state_s = ST_IDLE;
                    else                   state_s = ST_HIT;
                end
                ST_RESPAWN_WAIT: begin
                    if (cnt_r == RESPAWN_LAST) begin
                        if (auto_respawn) state_s = ST_LOAD_XY;
                        else              state_s = ST_IDLE;
                    end else begin
                        state_s = ST_RESPAWN_WAIT;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, counter, LFSR and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r              <= ST_IDLE;
            cnt_r                <= '0;
            lfsr_r               <= LFSR_SEED;
            sprite_write_xy      <= 1'b0;
            sprite_write_dxy     <= 1'b0;
            sprite_write_x       <= '0;
            sprite_write_y       <= w_y'(START_Y);
            sprite_write_dx      <= '0;
            sprite_write_dy      <= '0;
            sprite_enable_update <= 1'b0;
            busy                 <= 1'b0;
            hit                  <= 1'b0;
            escaped              <= 1'b0;
            spawn_count          <= 8'd0;
        end else begin
            state_r <= state_s;
            lfsr_r  <= lfsr_next(lfsr_r);
            // Counter restarts on every state entry and on abort.
            if (abort || (state_s != state_r)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            sprite_write_xy      <= (state_s == ST_LOAD_XY);
            sprite_write_dxy     <= (state_s == ST_LOAD_DXY);
            sprite_enable_update <= (state_s == ST_ENTER) || (state_s == ST_RUN);
            busy                 <= (state_s != ST_IDLE);
            hit                  <= (state_s == ST_HIT) && (state_r != ST_HIT);
            escaped              <= (state_s == ST_RESPAWN_WAIT) &&
                                    ((state_r == ST_ENTER) || (state_r == ST_RUN));
            // Position is captured when LOAD_XY is entered.
            if (state_s == ST_LOAD_XY) begin
                sprite_write_x <= spawn_x(lfsr_r);
                sprite_write_y <= w_y'(START_Y);
                spawn_count    <= spawn_count + 8'd1;
            end
            // Velocity is sampled during LOAD_XY, ready for the dxy strobe.
            if (state_r == ST_LOAD_XY) begin
                sprite_write_dx <= cfg_dx;
                sprite_write_dy <= cfg_dy;
            end
        end
    end

endmodule

// File: tb/tb_game_sprite_spawn_ctrl.sv
// Directed bench for game_sprite_spawn_ctrl with short delay parameters.
module tb_game_sprite_spawn_ctrl;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int WX = 10;
    localparam int WY = 9;
    localparam int SY = 17;

    logic            clk;
    logic            rst;
    logic            launch;
    logic            abort;
    logic            auto_respawn;
    logic [1:0]      cfg_dx;
    logic [1:0]      cfg_dy;
    logic            collision;
    logic            sprite_within_screen;
    logic            sprite_write_xy;
    logic            sprite_write_dxy;
    logic [WX-1:0]   sprite_write_x;
    logic [WY-1:0]   sprite_write_y;
    logic [1:0]      sprite_write_dx;
    logic [1:0]      sprite_write_dy;
    logic            sprite_enable_update;
    logic            busy;
    logic            hit;
    logic            escaped;
    logic [7:0]      spawn_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    game_sprite_spawn_ctrl #(
        .screen_width  (SW),
        .screen_height (SH),
        .SPRITE_WIDTH  (8),
        .DX_WIDTH      (2),
        .DY_WIDTH      (2),
        .START_Y       (SY),
        .RESPAWN_DELAY (4),
        .HIT_HOLD      (3),
        .ENTER_TIMEOUT (5),
        .CNT_W         (24)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .launch               (launch),
        .abort                (abort),
        .auto_respawn         (auto_respawn),
        .cfg_dx               (cfg_dx),
        .cfg_dy               (cfg_dy),
        .collision            (collision),
        .sprite_within_screen (sprite_within_screen),
        .sprite_write_xy      (sprite_write_xy),
        .sprite_write_dxy     (sprite_write_dxy),
        .sprite_write_x       (sprite_write_x),
        .sprite_write_y       (sprite_write_y),
        .sprite_write_dx      (sprite_write_dx),
        .sprite_write_dy      (sprite_write_dy),
        .sprite_enable_update (sprite_enable_update),
        .busy                 (busy),
        .hit                  (hit),
        .escaped              (escaped),
        .spawn_count          (spawn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR; m_prev holds the value the DUT saw at the last edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_prev <= m_lfsr;
        end
    end

    function automatic logic [WX-1:0] exp_x(input logic [15:0] l);
        logic [WX-1:0] raw;
        raw = l[WX-1:0];
        if (raw >= 10'd632) return raw - 10'd632;
        else return raw;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch from IDLE and step to the first ENTER cycle.
    task automatic launch_to_enter();
        launch = 1'b1;
        tick();
        launch = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0; launch = 1'b0; abort = 1'b0; auto_respawn = 1'b0;
        cfg_dx = 2'd0; cfg_dy = 2'd0; collision = 1'b0; sprite_within_screen = 1'b0;
        tick();
        tick();
        check_eq("rst_wxy",   32'(sprite_write_xy), 32'd0);
        check_eq("rst_wdxy",  32'(sprite_write_dxy), 32'd0);
        check_eq("rst_en",    32'(sprite_enable_update), 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_x",     32'(sprite_write_x), 32'd0);
        check_eq("rst_y",     32'(sprite_write_y), 32'd17);
        check_eq("rst_cnt",   32'(spawn_count), 32'd0);
        rst = 1'b1;
        repeat (7) tick();

        // Launch with dx=1 dy=2: xy at +1, dxy at +2, enable at +3.
        cfg_dx = 2'd1; cfg_dy = 2'd2; launch = 1'b1;
        tick();
        launch = 1'b0;
        check_eq("l_wxy",  32'(sprite_write_xy), 32'd1);
        check_eq("l_y",    32'(sprite_write_y), 32'd17);
        check_eq("l_x",    32'(sprite_write_x), 32'(exp_x(m_prev)));
        check_eq("l_cnt",  32'(spawn_count), 32'd1);
        check_eq("l_en0",  32'(sprite_enable_update), 32'd0);
        check_eq("l_busy", 32'(busy), 32'd1);
        tick();
        check_eq("l_wdxy", 32'(sprite_write_dxy), 32'd1);
        check_eq("l_wxy0", 32'(sprite_write_xy), 32'd0);
        check_eq("l_dx",   32'(sprite_write_dx), 32'd1);
        check_eq("l_dy",   32'(sprite_write_dy), 32'd2);
        check_eq("l_en1",  32'(sprite_enable_update), 32'd0);
        tick();
        check_eq("l_en",   32'(sprite_enable_update), 32'd1);
        check_eq("l_wdxy0", 32'(sprite_write_dxy), 32'd0);

        // Enter screen, run, leave: escape then respawn 4 cycles later.
        sprite_within_screen = 1'b1; auto_respawn = 1'b1;
        tick();
        tick();
        check_eq("run_en", 32'(sprite_enable_update), 32'd1);
        sprite_within_screen = 1'b0;
        tick();
        check_eq("esc_pulse", 32'(escaped), 32'd1);
        check_eq("esc_en",    32'(sprite_enable_update), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rw_wxy", 32'(sprite_write_xy), 32'd0);
            check_eq("rw_esc", 32'(escaped), 32'd0);
        end
        tick();
        check_eq("resp_wxy", 32'(sprite_write_xy), 32'd1);
        check_eq("resp_cnt", 32'(spawn_count), 32'd2);
        check_eq("resp_x",   32'(sprite_write_x), 32'(exp_x(m_prev)));
        auto_respawn = 1'b0;
        tick();
        tick();
        check_eq("to_en", 32'(sprite_enable_update), 32'd1);

        // Stay off screen: timeout after 5 ENTER cycles, then back to IDLE.
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("to_wait_esc", 32'(escaped), 32'd0);
            check_eq("to_wait_en",  32'(sprite_enable_update), 32'd1);
        end
        tick();
        check_eq("to_esc",  32'(escaped), 32'd1);
        check_eq("to_en0",  32'(sprite_enable_update), 32'd0);
        check_eq("to_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        check_eq("to_rw_busy", 32'(busy), 32'd1);
        tick();
        check_eq("to_idle", 32'(busy), 32'd0);
        check_eq("to_no_resp", 32'(sprite_write_xy), 32'd0);

        // Collision in RUN: hit pulse, 3-cycle freeze, launch ignored.
        launch_to_enter();
        sprite_within_screen = 1'b1;
        tick();
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check_eq("hit_pulse", 32'(hit), 32'd1);
        check_eq("hit_en",    32'(sprite_enable_update), 32'd0);
        check_eq("hit_busy",  32'(busy), 32'd1);
        launch = 1'b1;
        tick();
        launch = 1'b0;
        check_eq("hit_once",  32'(hit), 32'd0);
        check_eq("hit_nowxy", 32'(sprite_write_xy), 32'd0);
        tick();
        check_eq("hit_hold",  32'(busy), 32'd1);
        tick();
        check_eq("hit_idle",  32'(busy), 32'd0);
        tick();
        check_eq("hit_noq",   32'(sprite_write_xy), 32'd0);
        check_eq("hit_cnt",   32'(spawn_count), 32'd3);

        // Abort together with collision: IDLE, no hit.
        launch_to_enter();
        tick();
        abort = 1'b1; collision = 1'b1;
        tick();
        abort = 1'b0; collision = 1'b0;
        check_eq("ab_busy", 32'(busy), 32'd0);
        check_eq("ab_hit",  32'(hit), 32'd0);
        check_eq("ab_en",   32'(sprite_enable_update), 32'd0);
        tick();
        check_eq("ab_hit2", 32'(hit), 32'd0);
        check_eq("ab_cnt",  32'(spawn_count), 32'd4);
        sprite_within_screen = 1'b0;

        // Async reset while LOAD_DXY is about to be entered.
        launch = 1'b1;
        tick();
        launch = 1'b0;
        check_eq("ar_wxy1", 32'(sprite_write_xy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_wxy",  32'(sprite_write_xy), 32'd0);
        check_eq("ar_busy", 32'(busy), 32'd0);
        check_eq("ar_cnt",  32'(spawn_count), 32'd0);
        check_eq("ar_x",    32'(sprite_write_x), 32'd0);
        check_eq("ar_y",    32'(sprite_write_y), 32'd17);
        check_eq("ar_dx",   32'(sprite_write_dx), 32'd0);
        tick();
        check_eq("ar_wdxy", 32'(sprite_write_dxy), 32'd0);
        rst = 1'b1;
        launch = 1'b1;
        tick();
        launch = 1'b0;
        check_eq("ar2_wxy", 32'(sprite_write_xy), 32'd1);
        check_eq("ar2_cnt", 32'(spawn_count), 32'd1);
        check_eq("ar2_x",   32'(sprite_write_x), 32'(exp_x(m_prev)));
        tick();
        check_eq("ar2_wdxy", 32'(sprite_write_dxy), 32'd1);
        check_eq("ar2_dx",   32'(sprite_write_dx), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Many spawns: X always folded into range; count wraps past 255.
        for (int i = 0; i < 1000; i++) begin
            launch = 1'b1;
            tick();
            launch = 1'b0;
            check_eq("sp_x",   32'(sprite_write_x), 32'(exp_x(m_prev)));
            check_eq("sp_rng", 32'(sprite_write_x < 10'd632), 32'd1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check_eq("sp_wrap", 32'(spawn_count), 32'd233);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
